imem_prefetch_buffer: RTL and testbench

Sequential instruction prefetcher placed between the core fetch stage and instruction memory.
- Issues word-aligned sequential reads on the imem valid/ready interface.
- Queues returned words with their addresses in a small FIFO and presents them to the fetch stage through a valid/ready handshake.
- Flushes and refetches on a control-transfer redirect. Compressed-instruction splitting stays in the fetch stage.

---
 rtl/imem_prefetch_buffer.sv | 142 ++++++++++++++
 tb/tb_imem_prefetch_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word-aligned imem reads and queues
// {address, word} pairs in a small FIFO for the fetch stage; flushes on redirect.
module imem_prefetch_buffer #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           WORD_WIDTH   = 32,
   parameter int unsigned           DEPTH        = 2,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDRESS = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
   output logic [WORD_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic                  imem_valid_o,
   input  logic                  imem_ready_i,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [WORD_WIDTH-1:0] imem_wdata_o,
   output logic [3:0]            imem_we_o,
   input  logic [WORD_WIDTH-1:0] imem_rdata_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic                  discard_q, discard_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WORD_WIDTH-1:0] data_mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];

   logic                  accept, push, pop;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  unused_redirect_bits;

   assign redirect_target      = {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign unused_redirect_bits = ^redirect_addr_i[1:0];

   assign accept = (state_q == StBusy) && imem_ready_i;
   // Redirect overrides both FIFO operations in its cycle.
   assign pop    = instr_valid_o && instr_ready_i && !redirect_i;
   assign push   = accept && !discard_q && !redirect_i;

   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      next_addr_d = next_addr_q;
      discard_d   = discard_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      if (redirect_i) begin
         count_d     = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         next_addr_d = redirect_target;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            next_addr_d = req_addr_q + ADDR_WIDTH'(4);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      unique case (state_q)
         StIdle: begin
            // A redirect seen in IDLE issues straight away at its target.
            if (redirect_i || (count_q < DepthCnt) || discard_q) begin
               state_d    = StBusy;
               req_addr_d = next_addr_d;
            end
         end
         StBusy: begin
            if (accept) begin
               discard_d = 1'b0;
               if (count_d < DepthCnt) begin
                  req_addr_d = next_addr_d;
               end else begin
                  state_d = StIdle;
               end
            end else if (redirect_i) begin
               // Request already on the bus: hold it, drop its response later.
               discard_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         req_addr_q  <= BOOT_ADDRESS;
         next_addr_q <= BOOT_ADDRESS;
         discard_q   <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         next_addr_q <= next_addr_d;
         discard_q   <= discard_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '0;
            addr_mem_q[i] <= '0;
         end
      end else if (push) begin
         data_mem_q[wr_ptr_q] <= imem_rdata_i;
         addr_mem_q[wr_ptr_q] <= req_addr_q;
      end
   end

   assign instr_o       = data_mem_q[rd_ptr_q];
   assign instr_addr_o  = addr_mem_q[rd_ptr_q];
   assign instr_valid_o = (count_q != '0);
   assign imem_valid_o  = (state_q == StBusy);
   assign imem_addr_o   = req_addr_q;
   assign imem_wdata_o  = '0;
   assign imem_we_o     = '0;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Bench for imem_prefetch_buffer: directed cycle table, then random traffic
// checked against a queue-based transaction model.
module tb_imem_prefetch_buffer;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] BOOT  = 32'h100;
   localparam logic [31:0] KEY   = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_addr_i = '0;
   logic [31:0] instr_o, instr_addr_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic        imem_valid_o;
   logic        imem_ready_i = 1'b0;
   logic [31:0] imem_addr_o, imem_wdata_o;
   logic [3:0]  imem_we_o;
   logic [31:0] imem_rdata_i;
   logic        auto_data = 1'b1;
   logic [31:0] rdata_rand = '0;

   int checks = 0;
   int errors = 0;

   assign imem_rdata_i = auto_data ? (imem_addr_o ^ KEY) : rdata_rand;

   always #5 clk = ~clk;

   imem_prefetch_buffer #(
      .ADDR_WIDTH  (32),
      .WORD_WIDTH  (32),
      .DEPTH       (DEPTH),
      .BOOT_ADDRESS(BOOT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_i     (redirect_i),
      .redirect_addr_i(redirect_addr_i),
      .instr_o        (instr_o),
      .instr_addr_o   (instr_addr_o),
      .instr_valid_o  (instr_valid_o),
      .instr_ready_i  (instr_ready_i),
      .imem_valid_o   (imem_valid_o),
      .imem_ready_i   (imem_ready_i),
      .imem_addr_o    (imem_addr_o),
      .imem_wdata_o   (imem_wdata_o),
      .imem_we_o      (imem_we_o),
      .imem_rdata_i   (imem_rdata_i)
   );

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] raddr;
      logic        ir;
      logic        mr;
      logic        e_iv;
      logic [31:0] e_ia;
      logic        e_cv;
      logic [31:0] e_ca;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] ra,
                               input logic ir, input logic mr, input logic eiv,
                               input logic [31:0] eia, input logic ecv,
                               input logic [31:0] eca);
      vec_t v;
      v.rst = r; v.redir = rd; v.raddr = ra; v.ir = ir; v.mr = mr;
      v.e_iv = eiv; v.e_ia = eia; v.e_cv = ecv; v.e_ca = eca;
      return v;
   endfunction

   initial begin
      logic [31:0] fetch_addr;
      logic [31:0] prev_addr;
      logic        drop, prev_stall, acc, pop;
      int          idle_run;
      ent_t        e;

      // Row: inputs for this cycle and outputs expected during it.
      //                 rst redir raddr         ir mr  iv addr          cv head
      // Boot streaming, consumer always ready.
      vecs.push_back(mk(1, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h100,      0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h104,      1, 32'h100));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h108,      1, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h10C,      1, 32'h108));
      // Consumer stalled: fill two, single pop frees one slot, drain in order.
      vecs.push_back(mk(1, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  1, 32'h100,      0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  1, 32'h104,      1, 32'h100));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  0, 32'h0,        1, 32'h100));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  0, 32'h0,        1, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  1, 32'h108,      1, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  0, 32'h0,        1, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,         0, 1,  0, 32'h0,        1, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  0, 32'h0,        1, 32'h104));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  0, 32'h0,        1, 32'h108));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0,  1, 32'h10C,      0, 32'h0));
      // Redirect from IDLE, redirect during stall, redirect with ready, wrap.
      vecs.push_back(mk(1, 0, 32'h0,         1, 0,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 1, 32'h13,        1, 0,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0,  1, 32'h10,       0, 32'h0));
      vecs.push_back(mk(0, 1, 32'h200,       1, 0,  1, 32'h10,       0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0,  1, 32'h10,       0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h10,       0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h200,      0, 32'h0));
      vecs.push_back(mk(0, 1, 32'h8,         1, 1,  1, 32'h204,      1, 32'h200));
      vecs.push_back(mk(0, 1, 32'h40,        1, 1,  1, 32'h8,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h40,       0, 32'h0));
      vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 1,  1, 32'h44,       1, 32'h40));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'hFFFF_FFFC, 0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h0,        1, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0,  1, 32'h4,        1, 32'h0));
      // Async reset while BUSY with one entry queued, then restart at boot.
      vecs.push_back(mk(1, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h100,      0, 32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1,  1, 32'h104,      1, 32'h100));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst             = vecs[i].rst;
         redirect_i      = vecs[i].redir;
         redirect_addr_i = vecs[i].raddr;
         instr_ready_i   = vecs[i].ir;
         imem_ready_i    = vecs[i].mr;
         #1;
         chk($sformatf("v%0d imem_valid", i), 32'(imem_valid_o), 32'(vecs[i].e_iv));
         if (vecs[i].e_iv) chk($sformatf("v%0d imem_addr", i), imem_addr_o, vecs[i].e_ia);
         chk($sformatf("v%0d instr_valid", i), 32'(instr_valid_o), 32'(vecs[i].e_cv));
         if (vecs[i].e_cv || vecs[i].rst) begin
            chk($sformatf("v%0d instr_addr", i), instr_addr_o, vecs[i].e_ca);
            chk($sformatf("v%0d instr", i), instr_o,
                vecs[i].rst ? 32'h0 : (vecs[i].e_ca ^ KEY));
         end
         if (i == 2) begin
            chk("wdata tied", imem_wdata_o, 32'h0);
            chk("we tied", 32'(imem_we_o), 32'h0);
         end
      end

      // Random traffic against the transaction model.
      @(negedge clk);
      rst = 1'b1; redirect_i = 1'b0; instr_ready_i = 1'b0; imem_ready_i = 1'b0;
      @(negedge clk);
      rst = 1'b0; auto_data = 1'b0;
      q.delete();
      fetch_addr = BOOT; drop = 1'b0; prev_stall = 1'b0; prev_addr = '0; idle_run = 0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         chk("rnd instr_valid", 32'(instr_valid_o), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("rnd instr_addr", instr_addr_o, q[0].a);
            chk("rnd instr", instr_o, q[0].d);
         end
         if (prev_stall) begin
            chk("rnd hold valid", 32'(imem_valid_o), 32'h1);
            chk("rnd hold addr", imem_addr_o, prev_addr);
         end
         if (imem_valid_o && !drop) chk("rnd imem_addr", imem_addr_o, fetch_addr);
         if (imem_valid_o) chk("rnd reserved slot", 32'(q.size() < DEPTH), 32'h1);
         checks++;
         assert (q.size() <= DEPTH) else begin
            errors++;
            $display("FAIL rnd overflow: got %0d entries expected at most %0d", q.size(), DEPTH);
         end
         if (!imem_valid_o && q.size() < DEPTH) idle_run++;
         else idle_run = 0;
         chk("rnd starve", 32'(idle_run > 1), 32'h0);

         redirect_i    = ($urandom_range(0, 19) == 0);
         redirect_addr_i = ($urandom_range(0, 7) == 0) ?
                           (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
         instr_ready_i = ($urandom_range(0, 9) < 6);
         imem_ready_i  = ($urandom_range(0, 9) < 6);
         rdata_rand    = $urandom;

         acc = imem_valid_o && imem_ready_i;
         pop = instr_valid_o && instr_ready_i;
         if (redirect_i) begin
            q.delete();
            if (imem_valid_o) drop = !imem_ready_i;
            fetch_addr = redirect_addr_i & ~32'h3;
         end else begin
            if (pop && q.size() != 0) void'(q.pop_front());
            if (acc) begin
               if (drop) begin
                  drop = 1'b0;
               end else begin
                  e.a = fetch_addr;
                  e.d = rdata_rand;
                  q.push_back(e);
                  fetch_addr = fetch_addr + 32'd4;
               end
            end
         end
         prev_stall = imem_valid_o && !imem_ready_i;
         prev_addr  = imem_addr_o;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
